axi_wr_responder: RTL and testbench
===================================

AXI_WR_RESPONDER -- requirements
Module: axi_wr_responder

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 4, AWLEN width (max 16 beats).
- SIZE_WIDTH, 3, AWSIZE width.
- DATA_WIDTH, 32, W data width (8/16/32/64 only).
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- ACLK  in  1  clock.
- ARESETn  in  1  reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/LEN/SIZE/2  write address request.
- AWVALID  in  1;  AWREADY  out  1  AW handshake.
- WDATA  in  DATA_WIDTH;  WSTRB  in  DATA_WIDTH/8;  WLAST  in  1  write beat.
- WVALID  in  1;  WREADY  out  1  W handshake.
- BID  out  ID_WIDTH;  BRESP  out  2;  BVALID  out  1;  BREADY  in  1  write response.
- mem_we  out  1;  mem_addr  out  ADDR_WIDTH;  mem_wdata  out  DATA_WIDTH;  mem_wstrb  out  DATA_WIDTH/8  backing-store write port.
REQ-003 Reset ARESETn SHALL be synchronous, active-low; clock ACLK.

Function
REQ-004 FSM SHALL have states IDLE, DATA, RESP; one burst in flight at a time.
REQ-005 IDLE: AWREADY=1, WREADY=0, BVALID=0; AWVALID&AWREADY SHALL latch ID, ADDR, LEN, SIZE, BURST, clear beat counter and error flag, go to DATA next cycle.
REQ-006 DATA: AWREADY=0, WREADY=1; each WVALID&WREADY is one beat; AW and W SHALL never handshake in the same cycle.
REQ-007 mem_we SHALL equal WVALID&WREADY&~err combinationally; mem_addr = current beat address register, mem_wdata = WDATA, mem_wstrb = WSTRB, same cycle.
REQ-008 Beat address after each beat: FIXED(00) unchanged; INCR(01) next = (addr & ~(2^SIZE-1)) + 2^SIZE, modulo 2^ADDR_WIDTH; WRAP(10) increment as INCR with bits below log2(2^SIZE*(LEN+1)) wrapping inside that aligned window.
REQ-009 Error (SLVERR) SHALL be flagged at AW acceptance if 2^AWSIZE > DATA_WIDTH/8, AWBURST=11, or WRAP with AWLEN not in {1,3,7,15}; erroneous bursts still consume all LEN+1 beats with mem_we=0.
REQ-010 Beat counter SHALL be authoritative: beat LEN+1 ends the burst; WLAST=1 on an earlier beat or WLAST=0 on the final beat SHALL set err for the response (writes already issued are not undone, later beats suppressed).
REQ-011 Final beat handshake SHALL transition to RESP next cycle; WREADY=0 in RESP.
REQ-012 RESP: BVALID=1, BID=latched ID, BRESP=00 (OKAY) or 10 (SLVERR); BID/BRESP stable while BVALID&~BREADY; BVALID&BREADY SHALL return to IDLE next cycle.
REQ-013 Minimum burst cost: AW cycle + LEN+1 beat cycles + 1 B cycle; AWREADY reasserts the cycle after B handshake.

Reset
REQ-014 Under ARESETn=0: state IDLE, AWREADY=0 during reset then 1 first cycle after, WREADY=0, BVALID=0, BID=0, BRESP=00, mem_we=0, mem_addr=0, counters and err cleared.
REQ-015 Reset mid-burst SHALL abandon burst with no B response; remaining W beats after reset are not accepted until a new AW.

Verification
REQ-016 INCR: AWID=3, AWADDR=0x100, AWLEN=3, AWSIZE=2, 4 beats WLAST on 4th -> mem_addr 0x100,0x104,0x108,0x10C with mem_we=1; BID=3, BRESP=00.
REQ-017 WRAP: AWADDR=0x38, AWLEN=3, AWSIZE=2 -> mem_addr 0x38,0x3C,0x30,0x34; BRESP=00.
REQ-018 FIXED with WVALID gaps and BREADY held low 3 cycles: AWADDR=0x20, AWLEN=2 -> three writes to 0x20, BVALID/BID/BRESP held stable until BREADY.
REQ-019 Error: AWSIZE=3 with DATA_WIDTH=32, AWLEN=1 -> 2 beats accepted, mem_we=0 throughout, BRESP=10; early WLAST on beat 1 of AWLEN=2 -> BRESP=10.
REQ-020 Reset asserted during DATA after 1 of 4 beats -> no BVALID, AWREADY=1 first cycle after release, next burst completes normally.

Source files
------------

// File: rtl/axi_wr_responder.sv
// AXI4 write-channel slave: accepts one burst at a time, forwards beats to a
// backing-store write port, and returns a single B response per burst.
module axi_wr_responder #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned SIZE_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [SIZE_WIDTH-1:0]   AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
    localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e                  state_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [SIZE_WIDTH-1:0]   size_q;
    logic [1:0]              burst_q;
    logic [LEN_WIDTH-1:0]    beat_q;
    logic                    err_q;
    logic [1:0]              bresp_q;

    logic                    aw_hs, w_hs, last_beat, wlast_bad, aw_err, wrap_len_ok;
    logic [ADDR_WIDTH-1:0]   step, incr_addr, wrap_mask, addr_d;

    always_comb begin
        aw_hs       = AWVALID && AWREADY;
        w_hs        = WVALID && WREADY;
        last_beat   = (beat_q == len_q);
        wlast_bad   = WLAST ^ last_beat;
        wrap_len_ok = (32'(AWLEN) == 1) || (32'(AWLEN) == 3) ||
                      (32'(AWLEN) == 7) || (32'(AWLEN) == 15);
        aw_err      = (32'(AWSIZE) > MAX_SIZE) || (AWBURST == 2'b11) ||
                      ((AWBURST == 2'b10) && !wrap_len_ok);

        step      = ADDR_WIDTH'(1) << size_q;
        incr_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
        // Wrap window is step*(len+1) bytes, aligned to its own size.
        wrap_mask = (step * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1))) - ADDR_WIDTH'(1);
        unique case (burst_q)
            2'b00:   addr_d = addr_q;
            2'b10:   addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: addr_d = incr_addr;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (aw_hs) begin
                        id_q    <= AWID;
                        addr_q  <= AWADDR;
                        len_q   <= AWLEN;
                        size_q  <= AWSIZE;
                        burst_q <= AWBURST;
                        beat_q  <= '0;
                        err_q   <= aw_err;
                        bresp_q <= 2'b00;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        addr_q <= addr_d;
                        beat_q <= beat_q + LEN_WIDTH'(1);
                        if (wlast_bad) err_q <= 1'b1;
                        if (last_beat) begin
                            bresp_q <= (err_q || wlast_bad) ? 2'b10 : 2'b00;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (BREADY) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // AWREADY is gated by reset so it drops during reset yet is up the first cycle after.
    always_comb begin
        AWREADY   = (state_q == StIdle) && ARESETn;
        WREADY    = (state_q == StData);
        BVALID    = (state_q == StResp);
        BID       = id_q;
        BRESP     = bresp_q;
        mem_we    = w_hs && !err_q;
        mem_addr  = addr_q;
        mem_wdata = WDATA;
        mem_wstrb = WSTRB;
    end
endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder: INCR/WRAP/FIXED bursts, error bursts,
// B back-pressure and mid-burst reset.
module tb_axi_wr_responder;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_vec = 0;
    int n_err = 0;

    axi_wr_responder dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        #1 chk("awready_idle", AWREADY, 1'b1);
        chk("wready_idle", WREADY, 1'b0);
        next_cycle();
        AWVALID = 1'b0;
        #1 chk("awready_data", AWREADY, 1'b0);
        chk("wready_data", WREADY, 1'b1);
    endtask

    task automatic do_beat(input string tag, input logic [31:0] data, input logic last,
                           input logic we, input logic [31:0] addr);
        WDATA = data; WSTRB = 4'hf; WLAST = last; WVALID = 1'b1;
        #1 chk({tag, "_we"}, mem_we, we);
        if (we) begin
            chk({tag, "_addr"}, mem_addr, addr);
            chk({tag, "_wdata"}, mem_wdata, data);
            chk({tag, "_wstrb"}, mem_wstrb, 4'hf);
        end
        next_cycle();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic do_gap(input string tag);
        WVALID = 1'b0;
        #1 chk({tag, "_gap_we"}, mem_we, 1'b0);
        next_cycle();
    endtask

    task automatic do_resp(input string tag, input logic [3:0] id, input logic [1:0] resp,
                           input int hold);
        BREADY = 1'b0;
        #1;
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_bvalid"}, BVALID, 1'b1);
            chk({tag, "_bid"}, BID, id);
            chk({tag, "_bresp"}, BRESP, resp);
            chk({tag, "_wready_resp"}, WREADY, 1'b0);
            if (i < hold) begin
                next_cycle();
                #1;
            end
        end
        BREADY = 1'b1;
        next_cycle();
        BREADY = 1'b0;
        #1 chk({tag, "_bvalid_done"}, BVALID, 1'b0);
        chk({tag, "_awready_back"}, AWREADY, 1'b1);
    endtask

    initial begin
        ARESETn = 1'b0;
        next_cycle();
        next_cycle();
        #1 chk("rst_awready", AWREADY, 1'b0);
        chk("rst_wready", WREADY, 1'b0);
        chk("rst_bvalid", BVALID, 1'b0);
        chk("rst_bid", BID, 4'h0);
        chk("rst_bresp", BRESP, 2'b00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        ARESETn = 1'b1;
        #1 chk("rst_release_awready", AWREADY, 1'b1);

        // INCR, 4 beats of 4 bytes
        do_aw(4'd3, 32'h100, 4'd3, 3'd2, 2'b01);
        do_beat("incr0", 32'hA0, 1'b0, 1'b1, 32'h100);
        do_beat("incr1", 32'hA1, 1'b0, 1'b1, 32'h104);
        do_beat("incr2", 32'hA2, 1'b0, 1'b1, 32'h108);
        do_beat("incr3", 32'hA3, 1'b1, 1'b1, 32'h10C);
        do_resp("incr", 4'd3, 2'b00, 0);

        // WRAP in a 16-byte window
        do_aw(4'd1, 32'h38, 4'd3, 3'd2, 2'b10);
        do_beat("wrap0", 32'hB0, 1'b0, 1'b1, 32'h38);
        do_beat("wrap1", 32'hB1, 1'b0, 1'b1, 32'h3C);
        do_beat("wrap2", 32'hB2, 1'b0, 1'b1, 32'h30);
        do_beat("wrap3", 32'hB3, 1'b1, 1'b1, 32'h34);
        do_resp("wrap", 4'd1, 2'b00, 0);

        // FIXED with W gaps and B back-pressure
        do_aw(4'd7, 32'h20, 4'd2, 3'd2, 2'b00);
        do_beat("fix0", 32'hC0, 1'b0, 1'b1, 32'h20);
        do_gap("fix0");
        do_beat("fix1", 32'hC1, 1'b0, 1'b1, 32'h20);
        do_gap("fix1a");
        do_gap("fix1b");
        do_beat("fix2", 32'hC2, 1'b1, 1'b1, 32'h20);
        do_resp("fix", 4'd7, 2'b00, 3);

        // Oversize beat: both beats suppressed
        do_aw(4'd9, 32'h80, 4'd1, 3'd3, 2'b01);
        do_beat("size0", 32'hD0, 1'b0, 1'b0, 32'h0);
        do_beat("size1", 32'hD1, 1'b1, 1'b0, 32'h0);
        do_resp("size", 4'd9, 2'b10, 0);

        // Early WLAST on beat 1 of 3: beat 2 suppressed
        do_aw(4'd2, 32'h200, 4'd2, 3'd2, 2'b01);
        do_beat("early0", 32'hE0, 1'b1, 1'b1, 32'h200);
        do_beat("early1", 32'hE1, 1'b0, 1'b0, 32'h0);
        do_beat("early2", 32'hE2, 1'b1, 1'b0, 32'h0);
        do_resp("early", 4'd2, 2'b10, 0);

        // Reserved burst type
        do_aw(4'd4, 32'h300, 4'd0, 3'd2, 2'b11);
        do_beat("rsvd0", 32'hF0, 1'b1, 1'b0, 32'h0);
        do_resp("rsvd", 4'd4, 2'b10, 0);

        // Reset after 1 of 4 beats abandons the burst
        do_aw(4'd6, 32'h400, 4'd3, 3'd2, 2'b01);
        do_beat("rst0", 32'h11, 1'b0, 1'b1, 32'h400);
        ARESETn = 1'b0;
        WVALID = 1'b1; WDATA = 32'h22;
        next_cycle();
        #1 chk("midrst_awready", AWREADY, 1'b0);
        chk("midrst_wready", WREADY, 1'b0);
        chk("midrst_bvalid", BVALID, 1'b0);
        chk("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        ARESETn = 1'b1;
        #1 chk("postrst_awready", AWREADY, 1'b1);
        chk("postrst_wready", WREADY, 1'b0);
        chk("postrst_mem_we", mem_we, 1'b0);
        next_cycle();
        #1 chk("postrst_bvalid", BVALID, 1'b0);
        WVALID = 1'b0;
        do_aw(4'd5, 32'h10, 4'd1, 3'd2, 2'b01);
        do_beat("after0", 32'h33, 1'b0, 1'b1, 32'h10);
        do_beat("after1", 32'h44, 1'b1, 1'b1, 32'h14);
        do_resp("after", 4'd5, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
